// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin, lockable arbiter sharing one data-memory port
//            between the CPU (requester 0) and a secondary master (requester 1).
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_lock,
  input  logic [3:0]  r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_lock,
  input  logic [3:0]  r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        m_en,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] c_lock_max = 4'(LOCK_MAX);

  typedef enum logic [1:0] {FREE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t     r_state;
  logic       r_rr_last;
  logic [3:0] r_lock_cnt;
  logic       r_rd_pend;
  logic       r_rd_id;

  logic        w_own_id, w_own_req, w_oth_req;
  logic        w_owned, w_forced, w_eff_rr;
  logic        w_any, w_win;
  logic        w_win_lock;
  logic [3:0]  w_win_we;
  logic [31:0] w_win_addr, w_win_wdata;

  always_comb begin
    w_own_id  = (r_state == OWN1);
    w_own_req = w_own_id ? r1_req : r0_req;
    w_oth_req = w_own_id ? r0_req : r1_req;
    w_owned   = 1'b0;
    w_forced  = 1'b0;
    if (r_state != FREE && w_own_req) begin
      if (r_lock_cnt == c_lock_max && w_oth_req)
        w_forced = 1'b1;
      else
        w_owned = 1'b1;
    end
    // A forced release arbitrates as if the owner was the last winner.
    w_eff_rr = w_forced ? w_own_id : r_rr_last;
    w_any    = (r0_req | r1_req) & ~reset;
    if (w_owned)
      w_win = w_own_id;
    else if (r0_req & r1_req)
      w_win = ~w_eff_rr;
    else
      w_win = r1_req;
    w_win_lock  = w_win ? r1_lock  : r0_lock;
    w_win_we    = w_win ? r1_we    : r0_we;
    w_win_addr  = w_win ? r1_addr  : r0_addr;
    w_win_wdata = w_win ? r1_wdata : r0_wdata;
  end

  assign r0_gnt  = w_any & ~w_win;
  assign r1_gnt  = w_any &  w_win;
  assign m_en    = w_any;
  assign m_we    = w_any ? w_win_we : 4'h0;
  assign m_addr  = w_any ? (w_win_addr & 32'hFFFF_FFFC) : 32'h0;
  assign m_wdata = w_any ? w_win_wdata : 32'h0;

  assign r0_rvalid = r_rd_pend & ~r_rd_id & ~reset;
  assign r1_rvalid = r_rd_pend &  r_rd_id & ~reset;
  assign r0_rdata  = r0_rvalid ? m_rdata : 32'h0;
  assign r1_rdata  = r1_rvalid ? m_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FREE;
      r_rr_last  <= 1'b1;
      r_lock_cnt <= 4'd0;
      r_rd_pend  <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      r_rd_pend <= w_any && (w_win_we == 4'h0);
      if (w_any) begin
        r_rd_id   <= w_win;
        r_rr_last <= w_win;
      end
      if (w_any && w_win_lock) begin
        if (w_owned) begin
          if (r_lock_cnt != c_lock_max)
            r_lock_cnt <= r_lock_cnt + 4'd1;
        end else begin
          r_state    <= w_win ? OWN1 : OWN0;
          r_lock_cnt <= 4'd1;
        end
      end else begin
        r_state    <= FREE;
        r_lock_cnt <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed and randomized checks of dmem_arbiter against a model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 0, r0_lock = 0, r1_req = 0, r1_lock = 0;
  logic [3:0]  r0_we = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, m_en;
  logic [31:0] r0_rdata, r1_rdata, m_addr, m_wdata;
  logic [3:0]  m_we;
  logic [31:0] m_rdata = 0;

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // Reference model: owner (-1 none), burst count, last winner, pending read.
  int own = -1, cnt = 0, rr = 1, pid = 0;
  bit pend = 0;
  int win = -1;
  bit owned = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set0(input bit q, input bit l, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    r0_req = q; r0_lock = l; r0_we = w; r0_addr = a; r0_wdata = d;
  endtask

  task automatic set1(input bit q, input bit l, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    r1_req = q; r1_lock = l; r1_we = w; r1_addr = a; r1_wdata = d;
  endtask

  // Let inputs settle, decide the model winner and compare all outputs.
  task automatic settle();
    bit q[2];
    logic [3:0] we[2];
    logic [31:0] ad[2], wd[2];
    int last;
    bit rv[2];
    q  = '{r0_req, r1_req};
    we = '{r0_we, r1_we};
    ad = '{r0_addr, r1_addr};
    wd = '{r0_wdata, r1_wdata};
    #3;
    win = -1; owned = 0; last = rr;
    if (!reset) begin
      if (own >= 0 && q[own]) begin
        if (cnt >= LOCK_MAX && q[1-own]) last = own;
        else begin win = own; owned = 1; end
      end
      if (win < 0) begin
        if (q[0] && q[1]) win = 1 - last;
        else if (q[0]) win = 0;
        else if (q[1]) win = 1;
      end
    end
    rv[0] = !reset && pend && pid == 0;
    rv[1] = !reset && pend && pid == 1;
    check("gnt0",   r0_gnt, win == 0);
    check("gnt1",   r1_gnt, win == 1);
    check("m_en",   m_en,   win >= 0);
    check("m_we",   m_we,   win >= 0 ? we[win] : 4'h0);
    check("m_addr", m_addr, win >= 0 ? (ad[win] & ~32'h3) : 32'h0);
    check("m_wdata", m_wdata, win >= 0 ? wd[win] : 32'h0);
    check("rvalid0", r0_rvalid, rv[0]);
    check("rvalid1", r1_rvalid, rv[1]);
    check("rdata0", r0_rdata, rv[0] ? m_rdata : 32'h0);
    check("rdata1", r1_rdata, rv[1] ? m_rdata : 32'h0);
  endtask

  // Clock edge: advance the model by the rules, then move 1 time unit past it.
  task automatic advance();
    bit lk[2];
    logic [3:0] we[2];
    lk = '{r0_lock, r1_lock};
    we = '{r0_we, r1_we};
    @(posedge clk);
    if (reset) begin
      own = -1; cnt = 0; rr = 1; pend = 0;
    end else begin
      pend = (win >= 0) && (we[win] == 4'h0);
      if (win >= 0) begin rr = win; pid = win; end
      if (win >= 0 && lk[win]) begin
        if (owned) cnt = (cnt < LOCK_MAX) ? cnt + 1 : cnt;
        else begin own = win; cnt = 1; end
      end else begin
        own = -1; cnt = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    settle(); advance();
    reset = 1'b0;
  endtask

  initial begin
    int seq3[6];
    bit keep0, keep1;
    seq3 = '{1, 1, 1, 1, 0, 1};
    @(posedge clk); #1;

    // Reset with both requests up: nothing may be granted.
    set0(1, 0, 0, 32'h10, 0); set1(1, 0, 4'hF, 32'h20, 32'h5);
    settle();
    check("rst_gnt0", r0_gnt, 0);
    check("rst_m_en", m_en, 0);
    advance();
    reset = 1'b0;

    // Single read by requester 0.
    set0(1, 0, 0, 32'h106, 0); set1(0, 0, 0, 0, 0);
    settle();
    check("t1_gnt", r0_gnt, 1);
    check("t1_addr", m_addr, 32'h104);
    advance();
    set0(0, 0, 0, 0, 0); m_rdata = 32'hDEADBEEF;
    settle();
    check("t1_rdata", r0_rdata, 32'hDEADBEEF);
    check("t1_rv1", r1_rvalid, 0);
    advance();

    // Tie after reset alternates starting with requester 0.
    do_reset();
    set0(1, 0, 0, 32'h200, 0); set1(1, 0, 4'hF, 32'h40, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t2_gnt1", r1_gnt, i % 2);
      if (i % 2 == 1) begin
        check("t2_wdata", m_wdata, 32'h12345678);
        check("t2_we", m_we, 4'hF);
        check("t2_addr", m_addr, 32'h40);
      end
      advance();
    end

    // Locked burst by requester 1 is cut off after LOCK_MAX transfers.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set0(i > 0, 0, 4'h1, 32'h300, 32'hA);
      set1(1, 1, 4'hF, 32'h400 + 32'(4 * i), 32'(i));
      settle();
      check("t3_gnt1", r1_gnt, seq3[i]);
      advance();
    end

    // Lock release by requester 0, then a tie goes to requester 1.
    do_reset();
    set1(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set0(1, i < 2, 4'h3, 32'h500, 32'h77);
      settle(); advance();
    end
    set0(1, 0, 0, 32'h8, 0); set1(1, 0, 0, 32'hC, 0);
    settle();
    check("t4_tie", r1_gnt, 1);
    advance();

    // Back-to-back reads, then a write leaves no read return.
    set0(1, 0, 0, 32'h10, 0); set1(0, 0, 0, 0, 0);
    settle(); advance();
    set0(0, 0, 0, 0, 0); set1(1, 0, 0, 32'h14, 0); m_rdata = 32'h11111111;
    settle();
    check("t5_rv0", r0_rvalid, 1);
    check("t5_rd0", r0_rdata, 32'h11111111);
    advance();
    set1(1, 0, 4'hF, 32'h18, 32'h9); m_rdata = 32'h22222222;
    settle();
    check("t5_rv1", r1_rvalid, 1);
    check("t5_rd1", r1_rdata, 32'h22222222);
    advance();
    set1(0, 0, 0, 0, 0);
    settle();
    check("t5_norv", r0_rvalid | r1_rvalid, 0);
    advance();

    // Reset right after a read grant while requester 1 had ownership.
    do_reset();
    set1(1, 1, 4'hF, 32'h60, 32'h1);
    settle(); advance();
    set1(0, 0, 0, 0, 0); set0(1, 0, 0, 32'h64, 0);
    settle();
    check("t6_gnt0", r0_gnt, 1);
    advance();
    reset = 1'b1; set1(1, 0, 0, 32'h68, 0); m_rdata = 32'h33333333;
    settle();
    check("t6_norv", r0_rvalid, 0);
    check("t6_rdata", r0_rdata, 0);
    check("t6_m_en", m_en, 0);
    advance();
    reset = 1'b0;
    settle();
    check("t6_tie", r0_gnt, 1);
    advance();

    // Randomized traffic; requests are mostly held until granted.
    for (int i = 0; i < 600; i++) begin
      keep0 = r0_req && (win != 0) && ($urandom_range(0, 9) != 0);
      keep1 = r1_req && (win != 1) && ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 63) == 0);
      if (!keep0)
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom, $urandom);
      if (!keep1)
        set1($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom, $urandom);
      m_rdata = $urandom;
      settle(); advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
